func_eval_driver: RTL and testbench
===================================

FUNC_EVAL_DRIVER -- requirements
Module: func_eval_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4: input FIFO depth in entries, power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for eval_done, range 16..65535.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  host offers x sample (IEEE-754 single).
REQ-006 in_data  input  32  x sample.
REQ-007 in_ready  output  1  FIFO not full.
REQ-008 out_valid  output  1  result register holds y.
REQ-009 out_data  output  32  y (IEEE-754 single).
REQ-010 out_err  output  1  out_data is a timeout substitute (see Configuration).
REQ-011 out_ready  input  1  host accepts y.
REQ-012 eval_start  output  1  one-cycle start pulse to the evaluator.
REQ-013 eval_data  output  32  x presented to the evaluator.
REQ-014 eval_result  input  32  evaluator y.
REQ-015 eval_done  input  1  evaluator done level; stays high until the next start.
REQ-016 busy  output  1  FSM not in IDLE, or FIFO not empty.

Function
REQ-017 Input handshake: a word SHALL be written when in_valid && in_ready; in_ready = !full.
REQ-018 The FSM SHALL have states IDLE, LAUNCH, BLANK, WAIT, EMIT.
REQ-019 IDLE->LAUNCH SHALL occur when the FIFO is non-empty and out_valid==0; the FIFO head pops and is registered into eval_data on the same edge.
REQ-020 LAUNCH SHALL assert eval_start for exactly one cycle, then go to BLANK.
REQ-021 BLANK SHALL last one cycle; eval_done is ignored in BLANK because a stale done clears at the edge after start. It then goes to WAIT.
REQ-022 WAIT SHALL capture eval_result into out_data on the first cycle eval_done==1, then go to EMIT.
REQ-023 EMIT SHALL assert out_valid; on out_valid && out_ready, it SHALL clear out_valid and return to IDLE.
REQ-024 eval_data SHALL remain stable from LAUNCH until eval_done is captured.
REQ-025 Minimum per-sample latency, in_valid to out_valid with a 1-cycle evaluator, SHALL be 5 cycles: FIFO write, LAUNCH, BLANK, WAIT, EMIT register.
REQ-026 A simultaneous FIFO push and pop when the FIFO is full SHALL NOT be allowed, since in_ready is low. Push and pop together at 0 < count < DEPTH SHALL leave count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.
REQ-028 No second eval_start SHALL issue while a job is outstanding; at most one job is in flight.

Reset
REQ-029 Reset SHALL force state IDLE, empty the FIFO, and set eval_start=0, eval_data=0, out_valid=0, out_data=0, out_err=0, and the watchdog to 0.
REQ-030 Reset during WAIT SHALL abandon the job with no output; a late eval_done after reset SHALL be ignored because the state is IDLE.

Configuration
REQ-031 Macro FUNC_EVAL_TIMEOUT_EN, when defined: a watchdog SHALL count cycles in BLANK and WAIT. If it reaches TIMEOUT without done, the block SHALL load out_data=32'h7FC00000 (quiet NaN), set out_err=1, and go to EMIT.
REQ-032 FUNC_EVAL_TIMEOUT_EN undefined: no watchdog SHALL exist, WAIT SHALL wait indefinitely, and out_err SHALL be tied 0.

Structure
REQ-033 Package func_eval_pkg SHALL hold the FSM state enum, the QNAN constant 32'h7FC00000, and the default TIMEOUT.
REQ-034 The input buffer SHALL be sub-module fe_fifo (synchronous FIFO with parameters DEPTH and width 32).

Verification (bench evaluator model: done N cycles after start, stays high until next start)
REQ-035 Reset, then push x=32'h43000000 (128.0) with model y=32'h46808000 and N=3 -> one eval_start pulse, eval_data=32'h43000000, out_data=32'h46808000, out_err=0.
REQ-036 Stale done: eval_done held high from the previous job, new sample pushed -> result is not captured in BLANK; capture happens only after the model re-raises done.
REQ-037 Push 5 samples back-to-back with DEPTH=4 -> in_ready low after the 4th (+1 popped), all 5 results returned in order, no loss.
REQ-038 out_ready held low for 20 cycles with FIFO non-empty -> no new eval_start until y is accepted.
REQ-039 FUNC_EVAL_TIMEOUT_EN, TIMEOUT=16, model never asserts done -> out_data=32'h7FC00000 and out_err=1 at cycle 16 of wait; next sample proceeds normally.
REQ-040 Reset asserted during WAIT, then done arrives -> out_valid stays 0, and FIFO and busy are cleared.

Source files
------------

// File: rtl/func_eval_pkg.sv
// func_eval_pkg: shared types and constants for the function-evaluator driver.
//   state_e         : driver FSM states
//   QNAN            : quiet NaN substituted for a result that never arrived
//   DEFAULT_TIMEOUT : default watchdog limit, in cycles
//   WDOG_W          : watchdog counter width (covers TIMEOUT up to 65535)
package func_eval_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BLANK  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4
  } state_e;

  localparam logic [31:0] QNAN            = 32'h7FC0_0000;
  localparam int          DEFAULT_TIMEOUT = 255;
  localparam int          WDOG_W          = 16;

endpackage

// File: rtl/fe_fifo.sv
// fe_fifo: synchronous FIFO that buffers host x samples ahead of the evaluator.
// The head word is presented combinationally on pop_data while empty is low.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   push, push_data     write request and data (ignored while full)
//   pop                 read request (ignored while empty)
//   pop_data            current head word
//   full, empty         occupancy flags
// Parameters: DEPTH (power of two, >= 2), WIDTH.
module fe_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the counter guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/func_eval_driver.sv
// func_eval_driver: feeds buffered x samples one at a time to an external
// function evaluator and returns each y result to the host.
//
// state  | meaning
// IDLE   | no job; pops the FIFO head into eval_data when out_valid is low
// LAUNCH | eval_start high for this single cycle
// BLANK  | one dead cycle while a stale eval_done from the last job clears
// WAIT   | captures eval_result on the first cycle eval_done is high
// EMIT   | out_valid high until the host takes y
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid, in_data, in_ready     host x input (in_ready = FIFO not full)
//   out_valid, out_data, out_err    y output; out_err marks a timeout substitute
//   out_ready                       host accepts y
//   eval_start, eval_data           start pulse and x to the evaluator
//   eval_result, eval_done          evaluator y and done level
//   busy                            FSM not idle or FIFO not empty
// Parameters: DEPTH (FIFO entries), TIMEOUT (watchdog limit, 16..65535).
// Build macro FUNC_EVAL_TIMEOUT_EN: adds a watchdog over BLANK+WAIT that
// substitutes a quiet NaN with out_err=1 after TIMEOUT cycles. Without it the
// driver waits indefinitely and out_err is tied low.
module func_eval_driver
  import func_eval_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_err,
  input  logic        out_ready,
  output logic        eval_start,
  output logic [31:0] eval_data,
  input  logic [31:0] eval_result,
  input  logic        eval_done,
  output logic        busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be within 16..65535");
  end

  state_e      state_q, state_d;
  logic [31:0] eval_data_q, eval_data_d;
  logic [31:0] out_data_q, out_data_d;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [31:0] fifo_head;

  fe_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FUNC_EVAL_TIMEOUT_EN
  // Down-counter loaded in LAUNCH; reaching 1 in WAIT means TIMEOUT cycles
  // have been spent in BLANK+WAIT.
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              out_err_q, out_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    eval_data_d = eval_data_q;
    out_data_d  = out_data_q;
    fifo_pop    = 1'b0;
`ifdef FUNC_EVAL_TIMEOUT_EN
    wdog_d      = wdog_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          eval_data_d = fifo_head;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_BLANK;
`ifdef FUNC_EVAL_TIMEOUT_EN
        wdog_d  = WDOG_W'(TIMEOUT);
`endif
      end
      S_BLANK: begin
        state_d = S_WAIT;
`ifdef FUNC_EVAL_TIMEOUT_EN
        wdog_d  = wdog_q - WDOG_W'(1);
`endif
      end
      S_WAIT: begin
        if (eval_done) begin
          out_data_d = eval_result;
          state_d    = S_EMIT;
`ifdef FUNC_EVAL_TIMEOUT_EN
          out_err_d  = 1'b0;
          wdog_d     = '0;
        end else if (wdog_q == WDOG_W'(1)) begin
          out_data_d = QNAN;
          out_err_d  = 1'b1;
          wdog_d     = '0;
          state_d    = S_EMIT;
        end else begin
          wdog_d     = wdog_q - WDOG_W'(1);
`endif
        end
      end
      S_EMIT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      eval_data_q <= '0;
      out_data_q  <= '0;
`ifdef FUNC_EVAL_TIMEOUT_EN
      wdog_q      <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      eval_data_q <= eval_data_d;
      out_data_q  <= out_data_d;
`ifdef FUNC_EVAL_TIMEOUT_EN
      wdog_q      <= wdog_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign in_ready   = !fifo_full;
  assign eval_start = (state_q == S_LAUNCH);
  assign eval_data  = eval_data_q;
  assign out_valid  = (state_q == S_EMIT);
  assign out_data   = out_data_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
`ifdef FUNC_EVAL_TIMEOUT_EN
  assign out_err    = out_err_q;
`else
  assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_func_eval_driver.sv
module tb_func_eval_driver;

  localparam int DEPTH = 4;
`ifdef FUNC_EVAL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif
  localparam logic [31:0] QNAN_C = 32'h7FC0_0000;
  localparam logic [31:0] Y_MASK = 32'h0580_8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_ready = 1'b1;
  logic        eval_start;
  logic [31:0] eval_data;
  logic [31:0] eval_result = '0;
  logic        eval_done = 1'b0;
  logic        busy;

  func_eval_driver #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_ready   (out_ready),
    .eval_start  (eval_start),
    .eval_data   (eval_data),
    .eval_result (eval_result),
    .eval_done   (eval_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Evaluator behaviour: y = x ^ Y_MASK. cfg_n = cycles from start to done
  // (0 = never). cfg_stale holds the previous done one extra cycle.
  int cfg_n = 3;
  bit cfg_stale = 1'b0;

  function automatic logic [31:0] model_f(input logic [31:0] x);
    return x ^ Y_MASK;
  endfunction

  int          ev_k = 0;
  int          ev_n = 0;
  bit          ev_active = 1'b0;
  bit          ev_stale = 1'b0;
  logic [31:0] ev_x = '0;

  always @(negedge clk) begin
    if (ev_active) begin
      ev_k++;
      if (ev_k == 1) begin
        if (ev_n == 1) begin
          eval_result = model_f(ev_x);
          eval_done   = 1'b1;
        end else if (!ev_stale) begin
          eval_done = 1'b0;
        end
      end else if (ev_k == 2 && ev_stale) begin
        eval_done = 1'b0;
      end
      if (ev_n >= 2 && ev_k == ev_n) begin
        eval_result = model_f(ev_x);
        eval_done   = 1'b1;
      end
    end
    if (eval_start) begin
      ev_active = 1'b1;
      ev_k      = 0;
      ev_x      = eval_data;
      ev_n      = cfg_n;
      ev_stale  = cfg_stale;
    end
  end

  // Scoreboard: accepted x in order, expected {err, y} per launched job.
  logic [31:0] x_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] cur_x = '0;
  logic [31:0] exp_x;
  logic [32:0] exp_o;
  bit          outstanding = 1'b0;
  int          mon_start_cnt = 0;
  int          mon_out_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      x_q.delete();
      exp_q.delete();
      outstanding = 1'b0;
    end else begin
      if (in_valid && in_ready) x_q.push_back(in_data);
      if (eval_start) begin
        mon_start_cnt++;
        n_vec++;
        if (outstanding) begin
          n_err++;
          $display("FAIL start_while_busy: eval_start=%b with a job in flight, required 0", eval_start);
        end
        if (x_q.size() == 0) begin
          n_err++;
          $display("FAIL start_no_input: eval_start with no sample pending");
        end else begin
          exp_x = x_q.pop_front();
          n_vec++;
          if (eval_data !== exp_x) begin
            n_err++;
            $display("FAIL eval_data_order: got %h, required %h", eval_data, exp_x);
          end
          cur_x = exp_x;
          exp_q.push_back((cfg_n == 0) ? {1'b1, QNAN_C} : {1'b0, model_f(exp_x)});
        end
        outstanding = 1'b1;
      end else if (outstanding && !out_valid) begin
        n_vec++;
        if (eval_data !== cur_x) begin
          n_err++;
          $display("FAIL eval_data_stable: got %h, required %h", eval_data, cur_x);
        end
      end
      if (out_valid && out_ready) begin
        mon_out_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_out: out_valid=1 data=%h with no job, required out_valid=0", out_data);
        end else begin
          exp_o = exp_q.pop_front();
          if ({out_err, out_data} !== exp_o) begin
            n_err++;
            $display("FAIL result: got err=%b y=%h, required err=%b y=%h",
                     out_err, out_data, exp_o[32], exp_o[31:0]);
          end
        end
        outstanding = 1'b0;
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic push_word(input logic [31:0] x, output int tries);
    bit acc;
    tries = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", tries);
    end
  endtask

  task automatic wait_outs(input int target, input string nm);
    int t = 0;
    while (mon_out_cnt < target && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    n_vec++;
    if (mon_out_cnt < target) begin
      n_err++;
      $display("FAIL %s: results returned %0d, required %0d", nm, mon_out_cnt, target);
    end
  endtask

  // Ends on a falling edge with seen set if out_valid is high there.
  task automatic wait_valid_neg(input int budget, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, out_err, eval_start, busy} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: ready/valid/err/start/busy=%b, required 10000",
               {in_ready, out_valid, out_err, eval_start, busy});
    end
    n_vec++;
    if (out_data !== 32'h0 || eval_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: out_data=%h eval_data=%h, required 0 and 0", out_data, eval_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int b, s, t, c;
    bit seen;
    b = mon_out_cnt;
    s = mon_start_cnt;
    cfg_n = 3; cfg_stale = 1'b0; out_ready = 1'b0;
    push_word(32'h4300_0000, t);
    wait_valid_neg(100, seen, c);
    n_vec++;
    if (!seen || out_data !== 32'h4680_8000 || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: valid=%b err=%b y=%h, required 1 0 46808000", seen, out_err, out_data);
    end
    n_vec++;
    if (mon_start_cnt - s !== 1 || eval_data !== 32'h4300_0000) begin
      n_err++;
      $display("FAIL single_launch: starts=%0d x=%h, required 1 43000000", mon_start_cnt - s, eval_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_outs(b + 1, "single_drain");
  endtask

  task automatic test_latency();
    int lat, b;
    bit seen;
    b = mon_out_cnt;
    cfg_n = 1; cfg_stale = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = $urandom;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_vec++;
    if (!seen || lat != 5) begin
      n_err++;
      $display("FAIL latency: got %0d cycles (seen=%b), required 5", lat, seen);
    end
    wait_outs(b + 1, "latency_drain");
  endtask

  task automatic test_stale();
    int b, t;
    b = mon_out_cnt;
    n_vec++;
    if (eval_done !== 1'b1) begin
      n_err++;
      $display("FAIL stale_setup: eval_done=%b, required 1", eval_done);
    end
    cfg_n = 4; cfg_stale = 1'b1; out_ready = 1'b1;
    push_word(ev_x ^ 32'h0000_1234, t);
    wait_outs(b + 1, "stale_drain");
    cfg_stale = 1'b0;
  endtask

  task automatic test_back_to_back();
    int b, t;
    b = mon_out_cnt;
    cfg_n = 2; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_word($urandom, t);
      n_vec++;
      if (t != 1) begin
        n_err++;
        $display("FAIL b2b_stall: push %0d took %0d cycles, required 1", i, t);
      end
    end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_full: in_ready=%b, required 0", in_ready);
    end
    @(posedge clk); #1;
    wait_outs(b + 5, "b2b_drain");
  endtask

  task automatic test_backpressure();
    int b, s, t, c;
    bit seen, bad;
    logic [31:0] d;
    b = mon_out_cnt;
    cfg_n = 2; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word($urandom, t);
    wait_valid_neg(100, seen, c);
    s = mon_start_cnt;
    d = out_data;
    bad = !seen;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (bad || mon_start_cnt != s || out_data !== d) begin
      n_err++;
      $display("FAIL backpressure: valid_drop=%b starts=%0d y=%h, required 0 %0d %h",
               bad, mon_start_cnt, out_data, s, d);
    end
    out_ready = 1'b1;
    wait_outs(b + 3, "backpressure_drain");
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int b, t;
    b = mon_out_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          push_word($urandom, t);
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          cfg_n = $urandom_range(1, 5);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_outs(b + 40, "random_drain");
  endtask

`ifdef FUNC_EVAL_TIMEOUT_EN
  task automatic test_timeout();
    int b, t, s, c, lat;
    bit seen;
    b = mon_out_cnt;
    s = mon_start_cnt;
    cfg_n = 0; out_ready = 1'b0;
    push_word($urandom, t);
    c = 0;
    while (mon_start_cnt == s && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < TO + 40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    n_vec++;
    if (!seen || lat != TO + 1) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d (seen=%b), required %0d", lat, seen, TO + 1);
    end
    n_vec++;
    if (out_data !== QNAN_C || out_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_value: err=%b y=%h, required 1 %h", out_err, out_data, QNAN_C);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_outs(b + 1, "timeout_drain");
    cfg_n = 2;
    push_word($urandom, t);
    wait_outs(b + 2, "after_timeout");
  endtask
`else
  task automatic test_no_timeout();
    int b, t;
    bit seen;
    b = mon_out_cnt;
    cfg_n = 300; out_ready = 1'b1;
    push_word($urandom, t);
    seen = 1'b0;
    repeat (290) begin
      @(negedge clk);
      if (out_valid || out_err) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (seen || busy !== 1'b1) begin
      n_err++;
      $display("FAIL no_watchdog: early_out=%b busy=%b, required 0 1", seen, busy);
    end
    wait_outs(b + 1, "slow_drain");
  endtask
`endif

  task automatic test_reset_in_wait();
    int s, t, c;
    bit seen;
    cfg_n = 8; out_ready = 1'b1;
    s = mon_start_cnt;
    push_word($urandom, t);
    push_word($urandom, t);
    c = 0;
    while (mon_start_cnt == s && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({out_valid, busy, in_ready} !== 3'b001 || eval_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_wait_clear: valid/busy/ready=%b x=%h, required 001 0",
               {out_valid, busy, in_ready}, eval_data);
    end
    @(posedge clk); #1;
    s = mon_start_cnt;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (seen || mon_start_cnt != s) begin
      n_err++;
      $display("FAIL reset_wait_late_done: activity=%b starts=%0d, required 0 %0d",
               seen, mon_start_cnt, s);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_stale();
    test_back_to_back();
    test_backpressure();
    test_random();
`ifdef FUNC_EVAL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench stopped");
  end

endmodule
